// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bus bundle between the fetch stage, instruction memory and decode.
//
// Memory side : o_mem_req / o_mem_addr out of fetch, i_mem_gnt / i_mem_rvalid /
//               i_mem_rdata / i_mem_err into fetch (one outstanding read).
// Decode side : o_valid / o_inst / o_imm / o_pc / o_predict / o_exception /
//               o_mcause out of fetch, i_ready into fetch.
// Signal names keep the fetch-stage point of view (o_ = driven by fetch).
// modport master is the fetch stage, modport slave is memory + decode.
interface ifu_fetch_if;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        i_mem_err;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_inst;
    logic [31:0] o_imm;
    logic [31:0] o_pc;
    logic        o_predict;
    logic        o_exception;
    logic [3:0]  o_mcause;

    modport master (
        output o_mem_req, o_mem_addr,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        output o_valid, o_inst, o_imm, o_pc, o_predict, o_exception, o_mcause,
        input  i_ready
    );

    modport slave (
        input  o_mem_req, o_mem_addr,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err,
        input  o_valid, o_inst, o_imm, o_pc, o_predict, o_exception, o_mcause,
        output i_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode.
//
// Owns the PC, issues one instruction read at a time, builds the sign-extended
// immediate, tags fetch faults with an mcause and hands one bundle at a time to
// decode over valid/ready. A flush from execute redirects the PC.
//
// Ports:
//   i_clock        clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   bus            ifu_fetch_if.master (memory req/gnt/rvalid + decode handoff)
//   i_flush        squash and redirect (highest priority)
//   i_redirect_pc  new PC when i_flush=1
//   i_stall        freeze the handoff; no new fetch is issued
//
// Build option: define IFU_STATIC_PREDICT_EN for backward-taken/forward-not-taken
// prediction (JAL and backward branches predicted taken). Without it o_predict
// is 0 and the next PC is always pc+4.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    ifu_fetch_if.master bus,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;   // the outstanding response belongs to a squashed PC
    logic [31:0] inst_q, inst_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] bpc_q, bpc_d;     // PC of the bundle presented to decode
    logic        pred_q, pred_d;
    logic        exc_q, exc_d;
    logic [3:0]  mcause_q, mcause_d;

    logic [31:0] resp_imm;
    logic        resp_pred;
    logic [31:0] next_pc;

    function automatic logic [31:0] gen_imm(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (w[6:2])
            5'b00000, 5'b00100, 5'b11001, 5'b11100: r = {{20{w[31]}}, w[31:20]};
            5'b01000: r = {{20{w[31]}}, w[31:25], w[11:7]};
            5'b11000: r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            5'b00101, 5'b01101: r = {w[31:12], 12'b0};
            5'b11011: r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef IFU_STATIC_PREDICT_EN
    function automatic logic predict_taken(input logic [4:0] op, input logic imm_sign);
        return (op == 5'b11011) || ((op == 5'b11000) && imm_sign);
    endfunction
`endif

    always_comb begin
        resp_imm = gen_imm(bus.i_mem_rdata);
`ifdef IFU_STATIC_PREDICT_EN
        resp_pred = predict_taken(bus.i_mem_rdata[6:2], resp_imm[31]);
`else
        resp_pred = 1'b0;
`endif
        // pc_q equals the bundle PC while in HOLD; wraps mod 2^32
        next_pc = pc_q + (pred_q ? imm_q : 32'd4);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        imm_d    = imm_q;
        bpc_d    = bpc_q;
        pred_d   = pred_q;
        exc_d    = exc_q;
        mcause_d = mcause_q;

        case (state_q)
            S_IDLE: begin
                if (i_flush) begin
                    pc_d = i_redirect_pc;
                end else if (!i_stall) begin
                    if (pc_q[1:0] != 2'b00) begin
                        // misaligned PC: raise the fault without touching the bus
                        state_d  = S_HOLD;
                        inst_d   = '0;
                        imm_d    = '0;
                        pred_d   = 1'b0;
                        exc_d    = 1'b1;
                        mcause_d = 4'd0;
                        bpc_d    = pc_q;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_flush) begin
                    pc_d = i_redirect_pc;
                    if (bus.i_mem_gnt) begin
                        // the read is already accepted; wait for and discard its data
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.i_mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    pc_d = i_redirect_pc;
                    if (bus.i_mem_rvalid) begin
                        // stale response arrives with the flush: nothing left outstanding
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.i_mem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = i_stall ? S_IDLE : S_REQ;
                    end else begin
                        state_d  = S_HOLD;
                        bpc_d    = pc_q;
                        exc_d    = bus.i_mem_err;
                        mcause_d = bus.i_mem_err ? 4'd1 : 4'd0;
                        inst_d   = bus.i_mem_err ? 32'd0 : bus.i_mem_rdata;
                        imm_d    = bus.i_mem_err ? 32'd0 : resp_imm;
                        pred_d   = bus.i_mem_err ? 1'b0 : resp_pred;
                    end
                end
            end
            S_HOLD: begin
                if (i_flush) begin
                    pc_d    = i_redirect_pc;
                    state_d = S_IDLE;
                end else if (bus.i_ready && !i_stall) begin
                    pc_d = next_pc;
                    // a misaligned target goes through IDLE so it faults there
                    state_d = (next_pc[1:0] == 2'b00) ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            inst_q   <= '0;
            imm_q    <= '0;
            bpc_q    <= '0;
            pred_q   <= 1'b0;
            exc_q    <= 1'b0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            imm_q    <= imm_d;
            bpc_q    <= bpc_d;
            pred_q   <= pred_d;
            exc_q    <= exc_d;
            mcause_q <= mcause_d;
        end
    end

    assign bus.o_mem_req   = (state_q == S_REQ);
    assign bus.o_mem_addr  = (state_q == S_REQ) ? pc_q : 32'd0;
    assign bus.o_valid     = (state_q == S_HOLD);
    assign bus.o_inst      = inst_q;
    assign bus.o_imm       = imm_q;
    assign bus.o_pc        = bpc_q;
    assign bus.o_predict   = pred_q;
    assign bus.o_exception = exc_q;
    assign bus.o_mcause    = mcause_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
`ifdef IFU_STATIC_PREDICT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect = '0;
    logic        stall = 1'b0;
    logic        ready = 1'b0;
    logic        hold_resp = 1'b0;
    logic [31:0] word_v = 32'h0000_0013;
    logic        err_v = 1'b0;
    logic        rv, pend, er;
    logic [31:0] rd;
    int          total = 0;
    int          bad = 0;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .bus           (bus.master),
        .i_flush       (flush),
        .i_redirect_pc (redirect),
        .i_stall       (stall)
    );

    always #5 clk = ~clk;

    // memory: grants immediately, answers the next cycle unless held back
    assign bus.i_mem_gnt    = bus.o_mem_req;
    assign bus.i_mem_rvalid = rv;
    assign bus.i_mem_rdata  = rd;
    assign bus.i_mem_err    = er;
    assign bus.i_ready      = ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv <= 1'b0; pend <= 1'b0; rd <= '0; er <= 1'b0;
        end else begin
            rv   <= !hold_resp && (bus.i_mem_gnt || pend);
            pend <= hold_resp && (bus.i_mem_gnt || pend);
            rd   <= word_v;
            er   <= err_v;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        err;
        logic [31:0] inst;
        logic [31:0] imm;
        logic        pred_cand;  // taken when prediction is built in
        logic        exc;
        logic [3:0]  mcause;
        logic [31:0] tk_next;    // target if predicted taken
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.o_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " valid timeout"}, {31'd0, bus.o_valid}, 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush = 1'b1;
        redirect = pc;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // handshake the current bundle; the next fetch is issued right after
    task automatic handoff(input string name, input logic [31:0] exp_addr);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({name, " next req"}, {31'd0, bus.o_mem_req}, 32'd1);
        chk({name, " next addr"}, bus.o_mem_addr, exp_addr);
    endtask

    initial begin
        logic        ep;
        logic [31:0] en;
        int          cnt, n;

        tbl[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[1] = '{32'h8000_0010, 32'hFE00_0EE3, 1'b0, 32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b1, 1'b0, 4'd0, 32'h8000_000C};
        tbl[2] = '{32'h8000_0020, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4'd1, 32'h0};
        tbl[3] = '{32'h8000_0040, 32'hFE51_2C23, 1'b0, 32'hFE51_2C23, 32'hFFFF_FFF8, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[4] = '{32'h8000_0050, 32'h1234_50B7, 1'b0, 32'h1234_50B7, 32'h1234_5000, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[5] = '{32'h8000_0080, 32'h0100_00EF, 1'b0, 32'h0100_00EF, 32'h0000_0010, 1'b1, 1'b0, 4'd0, 32'h8000_0090};
        tbl[6] = '{32'h8000_00A0, 32'h0020_9463, 1'b0, 32'h0020_9463, 32'h0000_0008, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[7] = '{32'h8000_00B0, 32'h0000_0033, 1'b0, 32'h0000_0033, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[8] = '{32'h8000_00C0, 32'hFFC0_8067, 1'b0, 32'hFFC0_8067, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'd0, 32'h0};
        tbl[9] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b0, 1'b0, 4'd0, 32'h0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst req", {31'd0, bus.o_mem_req}, 32'd0);
        chk("rst addr", bus.o_mem_addr, 32'd0);
        chk("rst valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst pc", bus.o_pc, 32'd0);
        chk("rst inst", bus.o_inst, 32'd0);
        chk("rst exc", {31'd0, bus.o_exception}, 32'd0);

        // reset release: valid on the third cycle, first fetch at RESET_PC
        rst_n = 1'b1;
        @(negedge clk);
        chk("A c1 req", {31'd0, bus.o_mem_req}, 32'd1);
        chk("A c1 addr", bus.o_mem_addr, 32'h8000_0000);
        chk("A c1 valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        chk("A c2 valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        chk("A c3 valid", {31'd0, bus.o_valid}, 32'd1);
        chk("A pc", bus.o_pc, 32'h8000_0000);
        chk("A imm", bus.o_imm, 32'd0);
        chk("A inst", bus.o_inst, 32'h0000_0013);
        handoff("A", 32'h8000_0004);

        // table: redirect to each PC, check the bundle and the follow-up fetch
        foreach (tbl[i]) begin
            word_v = tbl[i].word;
            err_v  = tbl[i].err;
            do_flush(tbl[i].pc);
            wait_valid($sformatf("T%0d", i));
            ep = tbl[i].pred_cand & PE;
            en = ep ? tbl[i].tk_next : tbl[i].pc + 32'd4;
            chk($sformatf("T%0d pc", i), bus.o_pc, tbl[i].pc);
            chk($sformatf("T%0d inst", i), bus.o_inst, tbl[i].inst);
            chk($sformatf("T%0d imm", i), bus.o_imm, tbl[i].imm);
            chk($sformatf("T%0d pred", i), {31'd0, bus.o_predict}, {31'd0, ep});
            chk($sformatf("T%0d exc", i), {31'd0, bus.o_exception}, {31'd0, tbl[i].exc});
            chk($sformatf("T%0d mcause", i), {28'd0, bus.o_mcause}, {28'd0, tbl[i].mcause});
            handoff($sformatf("T%0d", i), en);
            err_v = 1'b0;
        end

        // HOLD with ready low, then stall with ready high: bundle frozen, no fetch
        word_v = 32'h0000_0013;
        do_flush(32'h8000_0300);
        wait_valid("D");
        for (int c = 0; c < 8; c++) begin
            if (c == 5) begin
                stall = 1'b1;
                ready = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("D%0d valid", c), {31'd0, bus.o_valid}, 32'd1);
            chk($sformatf("D%0d req", c), {31'd0, bus.o_mem_req}, 32'd0);
            chk($sformatf("D%0d pc", c), bus.o_pc, 32'h8000_0300);
            chk($sformatf("D%0d inst", c), bus.o_inst, 32'h0000_0013);
        end
        stall = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        chk("D release valid", {31'd0, bus.o_valid}, 32'd0);
        chk("D release req", {31'd0, bus.o_mem_req}, 32'd1);
        chk("D release addr", bus.o_mem_addr, 32'h8000_0304);
        wait_valid("D2");
        chk("D2 pc", bus.o_pc, 32'h8000_0304);

        // misaligned redirect: fault without any bus request
        do_flush(32'h8000_0102);
        cnt = 0;
        n = 0;
        while (!bus.o_valid && n < 40) begin
            if (bus.o_mem_req) cnt++;
            @(negedge clk);
            n++;
        end
        chk("C valid", {31'd0, bus.o_valid}, 32'd1);
        chk("C no req", cnt, 32'd0);
        chk("C exc", {31'd0, bus.o_exception}, 32'd1);
        chk("C mcause", {28'd0, bus.o_mcause}, 32'd0);
        chk("C pc", bus.o_pc, 32'h8000_0102);
        chk("C inst", bus.o_inst, 32'd0);
        chk("C pred", {31'd0, bus.o_predict}, 32'd0);

        // flush while waiting: the late response must be thrown away
        hold_resp = 1'b1;
        do_flush(32'h8000_0200);
        n = 0;
        while (!bus.o_mem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("B old addr", bus.o_mem_addr, 32'h8000_0200);
        @(negedge clk);            // granted, now waiting on the held response
        do_flush(32'h8000_0100);
        hold_resp = 1'b0;
        cnt = 0;
        n = 0;
        while (!bus.o_mem_req && n < 40) begin
            if (bus.o_valid) cnt++;
            @(negedge clk);
            n++;
        end
        chk("B no stale valid", cnt, 32'd0);
        chk("B new req", {31'd0, bus.o_mem_req}, 32'd1);
        chk("B new addr", bus.o_mem_addr, 32'h8000_0100);
        wait_valid("B");
        chk("B pc", bus.o_pc, 32'h8000_0100);
        chk("B exc", {31'd0, bus.o_exception}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Fetch stage sitting directly upstream of the decode stage.
- Owns the PC, issues one instruction read at a time on a simple req/grant/rvalid bus, and generates the sign-extended immediate.
- Applies optional static branch prediction, tags fetch exceptions with an mcause, and hands one instruction at a time to decode over a valid/ready handshake.
- Redirects on flush from the execute stage.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- i_clock  in  1  clock, all state on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- o_mem_req  out  1  fetch request; held until i_mem_gnt.
- o_mem_addr  out  32  fetch address; stable while o_mem_req=1.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  read response valid, 1-cycle pulse.
- i_mem_rdata  in  32  instruction word.
- i_mem_err  in  1  access fault, qualified by i_mem_rvalid.
- o_valid  out  1  instruction bundle valid to decode.
- i_ready  in  1  decode accepts the bundle.
- o_inst  out  32  instruction.
- o_imm  out  32  sign-extended immediate.
- o_pc  out  32  instruction PC.
- o_predict  out  1  predicted taken.
- o_exception  out  1  fetch exception flag.
- o_mcause  out  4  exception cause.
- i_flush  in  1  squash and redirect.
- i_redirect_pc  in  32  new PC when i_flush=1.
- i_stall  in  1  freeze the handoff; no new fetch is issued.

Behaviour:
- Reset (async, i_reset_n=0):
  - State IDLE, pc=RESET_PC, drop=0.
  - All outputs 0.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE→REQ: next cycle, unless i_stall. If pc[1:0]!=0, go straight to HOLD with o_exception=1, o_mcause=0, o_inst=0; no bus request is issued.
  - REQ: o_mem_req=1, o_mem_addr=pc. On i_mem_gnt go to WAIT.
  - WAIT:
    - On i_mem_rvalid with drop=0: latch the bundle and go to HOLD.
    - On i_mem_err: o_exception=1, o_mcause=1, o_inst=0, o_predict=0.
    - On i_mem_rvalid with drop=1: discard the response, clear drop, go to REQ at the current pc.
  - HOLD: o_valid=1. On i_valid&i_ready&!i_stall, pc←next_pc and go to IDLE (or to REQ the same cycle if not stalled). The bundle is held stable while !i_ready.
- next_pc: pc+imm if o_predict, else pc+4. Arithmetic is mod 2^32 (wraps).
- Immediate by opcode[6:2]:
  - 00000, 00100, 11001, 11100: I-type.
  - 01000: S-type.
  - 11000: B-type.
  - 00101, 01101: U-type.
  - 11011: J-type.
  - Other opcodes: 0.
  - Bit 31 is the sign bit for all formats.
- i_flush has highest priority, above i_stall and handshakes:
  - pc←i_redirect_pc and o_valid←0 next cycle.
  - In REQ or IDLE: go to IDLE (REQ drops o_mem_req; a grant in the same cycle goes to WAIT with drop=1).
  - In WAIT: set drop=1 and stay in WAIT.
  - In HOLD: go to IDLE.
- i_stall: freezes the state and the bundle, except REQ→WAIT on grant, which must complete. A response arriving during stall is still latched.
- Exactly one outstanding bus transaction at a time.
- Latency: zero-wait memory gives o_valid 3 cycles after leaving IDLE (IDLE, REQ+gnt, WAIT+rvalid, HOLD).
- Throughput: one instruction per 3 cycles.

Optional Feature:
- IFU_STATIC_PREDICT_EN defined, BTFN prediction:
  - o_predict=1 for JAL.
  - o_predict=1 for B-type with imm[31]=1.
  - o_predict=0 otherwise, including JALR and faulted fetches.
- Undefined: o_predict tied 0 and next_pc is always pc+4; the immediate is still generated.

Test Plan:
- Reset release, zero-wait memory returning 32'h0000_0013 at 8000_0000 → o_valid on cycle 3, o_pc=8000_0000, o_imm=0, next fetch at 8000_0004.
- Word 32'hFE00_0EE3 (beq x0,x0,-4) at 8000_0010, macro on → o_imm=FFFF_FFFC, o_predict=1, next o_mem_addr=8000_000C. Macro off → o_predict=0, next address 8000_0014.
- Response with i_mem_err=1 at 8000_0020 → o_exception=1, o_mcause=1, o_inst=0, o_predict=0.
- i_flush with i_redirect_pc=8000_0100 while in WAIT → the stale rvalid is discarded, the next o_mem_addr is 8000_0100, and no o_valid is produced for the old PC.
- i_flush with i_redirect_pc=8000_0102 → no o_mem_req; o_valid with o_exception=1, o_mcause=0, o_pc=8000_0102.
- HOLD with i_ready=0 for 5 cycles, then i_stall=1 with i_ready=1 → bundle stable and no new request; the handoff occurs only once i_stall=0.
